// File: rtl/clm_inverse_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : clm_inverse_sequencer_if
// Brief    : Handshake, randomness and multiplier bundle for the CLM inverter.
// Revision : 1.0
// ============================================================================
interface clm_inverse_sequencer_if #(
    parameter int D = 4
);
    localparam int c_W = 8 + D;

    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_data;
    logic           rand_valid;
    logic           rand_ready;
    logic [D-1:0]   rand_r;
    logic [c_W-1:0] mul_p1;
    logic [c_W-1:0] mul_p2;
    logic [D-1:0]   mul_r;
    logic [c_W-1:0] mul_out;
    logic           busy;

    // Sequencer view
    modport slave (
        input  in_valid, in_data, out_ready, rand_valid, rand_r, mul_out,
        output in_ready, out_valid, out_data, rand_ready, mul_p1, mul_p2, mul_r, busy
    );

    // Environment view (S-box datapath, randomness source, multiplier)
    modport master (
        output in_valid, in_data, out_ready, rand_valid, rand_r, mul_out,
        input  in_ready, out_valid, out_data, rand_ready, mul_p1, mul_p2, mul_r, busy
    );
endinterface
`default_nettype wire

// File: rtl/clm_inverse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clm_inverse_sequencer
// Brief    : Computes masked x^254 over a shared external CLM multiplier.
// Revision : 1.0
// ============================================================================
module clm_inverse_sequencer #(
    parameter int D = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    clm_inverse_sequencer_if.slave   bus
);
    localparam int         c_W         = 8 + D;
    localparam logic [3:0] c_LAST_STEP = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_step;
    logic [c_W-1:0] r_x;
    logic [c_W-1:0] r_r2;
    logic [c_W-1:0] r_r3;
    logic [c_W-1:0] r_r12;
    logic [c_W-1:0] r_acc;
    logic [c_W-1:0] r_out;

    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_rand_ready;
    logic           w_fire;
    logic [c_W-1:0] w_p1;
    logic [c_W-1:0] w_p2;

    // An op only fires on a legal step with fresh randomness available.
    assign w_fire = (r_state == S_RUN) && bus.rand_valid && (r_step <= c_LAST_STEP);

    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_rand_ready = 1'b0;
        w_p1         = '0;
        w_p2         = '0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_rand_ready = 1'b1;
                // Addition chain 1,2,3,6,12,15,30,60,120,240,252,254
                case (r_step)
                    4'd0:    begin w_p1 = r_x;   w_p2 = r_x;   end
                    4'd1:    begin w_p1 = r_r2;  w_p2 = r_x;   end
                    4'd2:    begin w_p1 = r_r3;  w_p2 = r_r3;  end
                    4'd3:    begin w_p1 = r_acc; w_p2 = r_acc; end
                    4'd4:    begin w_p1 = r_r12; w_p2 = r_r3;  end
                    4'd5, 4'd6, 4'd7, 4'd8:
                             begin w_p1 = r_acc; w_p2 = r_acc; end
                    4'd9:    begin w_p1 = r_acc; w_p2 = r_r12; end
                    4'd10:   begin w_p1 = r_acc; w_p2 = r_r2;  end
                    default: begin w_p1 = '0;    w_p2 = '0;    end
                endcase
                if (r_step > c_LAST_STEP) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fire && (r_step == c_LAST_STEP)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_x     <= '0;
            r_r2    <= '0;
            r_r3    <= '0;
            r_r12   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && bus.in_valid) begin
                r_x    <= bus.in_data;
                r_step <= '0;
            end
            if (w_fire) begin
                case (r_step)
                    4'd0:    r_r2  <= bus.mul_out;
                    4'd1:    r_r3  <= bus.mul_out;
                    4'd3:    r_r12 <= bus.mul_out;
                    4'd10:   r_out <= bus.mul_out;
                    default: r_acc <= bus.mul_out;
                endcase
                // The counter parks at the last step instead of wrapping.
                if (r_step != c_LAST_STEP) begin
                    r_step <= r_step + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = r_out;
    assign bus.rand_ready = w_rand_ready;
    assign bus.mul_p1     = w_p1;
    assign bus.mul_p2     = w_p2;
    assign bus.mul_r      = bus.rand_r;
    assign bus.busy       = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_clm_inverse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clm_inverse_sequencer
// Brief    : Random-stimulus bench with a CLM multiplier and AES-field model.
// Revision : 1.0
// ============================================================================
module tb_clm_inverse_sequencer;
    localparam int          D      = 4;
    localparam int          W      = 8 + D;
    localparam logic [22:0] c_P    = 23'h11B;
    localparam logic [22:0] c_BEXT = 23'h129D;   // 0x11B * (x^4+x+1)

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] inv_tab [256];

    // Exponents of x held by each operand at each step of the chain
    int e1 [11] = '{1, 2, 3, 6, 12, 15, 30, 60, 120, 240, 252};
    int e2 [11] = '{1, 1, 3, 6, 3, 15, 30, 60, 120, 12, 2};

    clm_inverse_sequencer_if #(.D(D)) bus ();

    clm_inverse_sequencer #(.D(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] clmul(input logic [11:0] a, input logic [11:0] b);
        logic [22:0] acc = '0;
        for (int i = 0; i < 12; i++) if (b[i]) acc ^= (23'(a) << i);
        return acc;
    endfunction

    function automatic logic [22:0] pmod(input logic [22:0] v, input logic [22:0] m, input int deg);
        for (int i = 22; i >= deg; i--) if (v[i]) v ^= (m << (i - deg));
        return v;
    endfunction

    function automatic logic [11:0] clm_mul(input logic [11:0] a, input logic [11:0] b,
                                            input logic [3:0] r);
        logic [22:0] t = pmod(clmul(a, b), c_BEXT, 12) ^ clmul(12'(r), 12'(c_P));
        return t[11:0];
    endfunction

    function automatic logic [7:0] decode(input logic [11:0] enc);
        logic [22:0] t = pmod(23'(enc), c_P, 8);
        return t[7:0];
    endfunction

    function automatic logic [11:0] encode(input logic [7:0] x);
        logic [22:0] t = clmul(12'($urandom_range(0, 15)), 12'(c_P));
        return 12'(x) ^ t[11:0];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = a << 1;
            if (hi) a ^= 8'h1B;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gpow(input logic [7:0] x, input int e);
        logic [7:0] p = 8'h01;
        for (int i = 0; i < e; i++) p = gmul(p, x);
        return p;
    endfunction

    // The multiplier the sequencer drives
    assign bus.mul_out = clm_mul(bus.mul_p1, bus.mul_p2, bus.mul_r);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One inversion, called at a negedge with the block idle.
    task automatic run_inv(input logic [7:0] x, input int stall_step, input int stall_len,
                           input int bp_len, input int rst_step);
        int k, fired, stalled, hs;
        logic done;
        k = 0; fired = 0; stalled = 0; hs = 0; done = 1'b0;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_data    = encode(x);
        bus.in_valid   = 1'b1;
        bus.rand_valid = 1'b1;
        bus.rand_r     = 4'($urandom);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 12'($urandom);
        k = 1;
        while (!done && k < 200) begin
            if (bus.out_valid) begin
                done = 1'b1;
            end else begin
                if (rst_step >= 0 && fired == rst_step) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
                    chk("abort_busy", 32'(bus.busy), 32'd0);
                    chk("abort_rand_ready", 32'(bus.rand_ready), 32'd0);
                    return;
                end
                chk("run_in_ready", 32'(bus.in_ready), 32'd0);
                chk("run_rand_ready", 32'(bus.rand_ready), 32'd1);
                if (fired <= 10) begin
                    chk($sformatf("p1_x%0h_s%0d", x, fired), 32'(decode(bus.mul_p1)), 32'(gpow(x, e1[fired])));
                    chk($sformatf("p2_x%0h_s%0d", x, fired), 32'(decode(bus.mul_p2)), 32'(gpow(x, e2[fired])));
                end
                if (fired == stall_step && stalled < stall_len) begin
                    bus.rand_valid = 1'b0;
                    stalled++;
                end else begin
                    bus.rand_valid = 1'b1;
                end
                bus.rand_r = 4'($urandom);
                if (bus.rand_valid && bus.rand_ready) begin
                    hs++;
                    fired++;
                end
                tick();
                k++;
            end
        end
        if (!done) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        chk($sformatf("latency_x%0h", x), 32'(k), 32'(12 + stall_len));
        chk("result_in_ready", 32'(bus.in_ready), 32'd0);
        chk($sformatf("result_x%0h", x), 32'(decode(bus.out_data)), 32'(inv_tab[x]));
        bus.rand_valid = 1'b1;
        for (int i = 0; i < bp_len; i++) begin
            bus.out_ready = 1'b0;
            if (bus.rand_valid && bus.rand_ready) hs++;
            tick();
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_rand_ready", 32'(bus.rand_ready), 32'd0);
            chk("bp_result", 32'(decode(bus.out_data)), 32'(inv_tab[x]));
        end
        chk("rand_handshakes", 32'(hs), 32'd11);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("ack_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ack_in_ready", 32'(bus.in_ready), 32'd1);
        chk("ack_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus.rand_valid = 1'b0;
        bus.rand_r     = '0;

        // Reference inverse by exhaustive search; 0 maps to 0
        inv_tab[0] = 8'h00;
        for (int a = 1; a < 256; a++) begin
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
            end
        end

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rand_ready", 32'(bus.rand_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        chk("tab_53", 32'(inv_tab[8'h53]), 32'hCA);
        run_inv(8'h53, -1, 0, 0, -1);
        run_inv(8'h01, -1, 0, 0, -1);
        run_inv(8'h00, -1, 0, 0, -1);
        run_inv(8'hFF, -1, 0, 0, -1);

        // Randomness stall at step 5 and output backpressure
        run_inv(8'($urandom), 5, 3, 0, -1);
        run_inv(8'($urandom), -1, 0, 5, -1);

        // Reset in the middle of a run, then a fresh input
        run_inv(8'h53, -1, 0, 0, 6);
        run_inv(8'h02, -1, 0, 0, -1);

        for (int v = 0; v < 256; v++) begin
            run_inv(8'(v), $urandom_range(0, 10), $urandom_range(0, 2), $urandom_range(0, 1), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/clm_inverse_sequencer.md
Name: clm_inverse_sequencer

Overview:
- Sequencer that computes the masked GF(2^8) inverse, x^254, on a CLM-encoded state word.
- Drives one shared combinational CLM multiplier (post-reduction type) through a fixed 11-step addition chain. Squarings are issued as multiplications with both operands equal.
- Supplies one fresh refresh polynomial r per multiplication from an external randomness source.
- Sits between the S-box input register and the affine stage; ready/valid on both sides.

Parameters:
- d, 4, masking redundancy degree; state word width is 8+d, refresh polynomial width is d.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  sequencer can accept an input
- in_data  in  8+d  CLM-encoded input x
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  8+d  CLM-encoded x^254
- rand_valid  in  1  fresh r available
- rand_ready  out  1  r is consumed this cycle when rand_valid is also high
- rand_r  in  d  refresh polynomial
- mul_p1  out  8+d  multiplier operand 1
- mul_p2  out  8+d  multiplier operand 2
- mul_r  out  d  multiplier refresh input, equal to rand_r
- mul_out  in  8+d  multiplier product, combinational from mul_p1/mul_p2/mul_r
- busy  out  1  high when the state is not IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high; all state changes occur on the rising edge of clk.
- Registers: X, R2, R3, R12, ACC (each 8+d bits), step counter (4 bits), state, out_data register.
- Reset:
  - state goes to IDLE; step and all data registers go to 0.
  - out_valid=0, in_ready=1, rand_ready=0, busy=0, out_data=0.
  - rst overrides every other input in the same cycle, including mid-run. Any in-flight computation is discarded and no output is produced for it.
- States:
  - IDLE: in_ready=1. On in_valid: X<=in_data, step<=0, go to RUN.
  - RUN: in_ready=0, rand_ready=1. An op fires in a cycle only when rand_valid=1. On fire, mul_out is written to the step's destination and step increments. With rand_valid=0 there is no write and no increment; mul_p1/mul_p2 hold their values.
  - DONE: out_valid=1, in_ready=0, rand_ready=0. On out_ready: go to IDLE and drop out_valid. out_data is stable while out_valid=1 and out_ready=0.
- Step table (p1, p2 -> destination):
  - 0: X, X -> R2 (x^2)
  - 1: R2, X -> R3 (x^3)
  - 2: R3, R3 -> ACC (x^6)
  - 3: ACC, ACC -> R12 (x^12)
  - 4: R12, R3 -> ACC (x^15)
  - 5-8: ACC, ACC -> ACC (x^30, x^60, x^120, x^240)
  - 9: ACC, R12 -> ACC (x^252)
  - 10: ACC, R2 -> out_data (x^254); go to DONE.
- Multiplier drive:
  - mul_p1/mul_p2 are a combinational mux on step; they are 0 outside RUN.
  - mul_r = rand_r at all times.
  - The multiplier is shared only through this block; no other master drives it.
- Randomness: exactly 11 rand handshakes per inversion; r is never reused. rand_ready is high only in RUN.
- Latency:
  - in_valid accepted at edge E0; ops fire at edges E1..E11 when rand_valid is held high.
  - out_valid=1 in the cycle after E11, i.e. 12 cycles after acceptance.
  - Each cycle with rand_valid=0 in RUN adds one cycle of latency.
- Throughput: one inversion in flight; next input accepted in the cycle after the out_valid&out_ready handshake. in_ready and out_valid are never both 1.
- Step counter never exceeds 10 and does not wrap; steps 11-15 are unreachable. If the counter is ever at 11-15 in RUN, the block returns to IDLE on the next edge and produces no output.
- Arithmetic: the block performs no arithmetic and no XOR; all field operations happen in the external multiplier. Data registers are plain 8+d-bit loads.
- Zero input: x=0 encoded yields an encoding of 0; there is no special case.

Test Plan:
- Bench drives the real CLM multiplier with a fixed B_ext and checks by decoding out_data.
- Known vector, rand_valid tied 1: x=0x53 with random r -> decoded out 0xCA; out_valid exactly 12 cycles after acceptance; 11 rand handshakes counted.
- Edge values: x=0x01 -> 0x01; x=0x00 -> 0x00; x=0xFF -> 0x1C. Exhaustive sweep over 0x00..0xFF with random r must match the AES inverse table.
- Randomness stall: rand_valid low for 3 cycles while step=5 -> mul_p1/mul_p2 and step frozen over those cycles; out_valid at cycle 15; correct result.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_data unchanged, in_ready=0, no rand handshakes; IDLE one cycle after out_ready rises.
- Reset mid-run: assert rst at step 6 -> next cycle IDLE, in_ready=1, out_valid=0, busy=0. A new input x=0x02 then completes as 0x8D.
